// File: rtl/endp_inject_arbiter_pkg.sv
// Shared parameters and types for the endpoint injection arbiter.
// Sized for a 4-requester, 2-VC endpoint with 4-deep router buffers.
package endp_inject_arbiter_pkg;

    localparam int NREQ = 4;
    localparam int Fw   = 32;
    localparam int V    = 2;
    localparam int B    = 4;
    localparam int Vw   = (V > 1) ? $clog2(V) : 1;
    localparam int Cw   = $clog2(B + 1);
    localparam int Nw   = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef struct packed {
        logic hdr;
        logic tail;
    } ftype_t;

endpackage

// File: rtl/endp_inject_arbiter_if.sv
// Requester-side and router-side bundles of the injection arbiter.
// master drives the flit; slave answers with ready or credits.
interface endp_req_if;
    import endp_inject_arbiter_pkg::*;

    logic [NREQ-1:0]    valid;
    logic [NREQ-1:0]    ready;
    logic [NREQ-1:0]    hdr;
    logic [NREQ-1:0]    tail;
    logic [NREQ*Vw-1:0] vc;
    logic [NREQ*Fw-1:0] flit;

    modport master (
        output valid, hdr, tail, vc, flit,
        input  ready
    );

    modport slave (
        input  valid, hdr, tail, vc, flit,
        output ready
    );

endinterface

interface endp_flit_if;
    import endp_inject_arbiter_pkg::*;

    logic          wr;
    logic [Fw-1:0] flit;
    logic          hdr;
    logic          tail;
    logic [V-1:0]  vc;
    logic [V-1:0]  credit_in;

    modport master (
        output wr, flit, hdr, tail, vc,
        input  credit_in
    );

    modport slave (
        input  wr, flit, hdr, tail, vc,
        output credit_in
    );

endinterface

// File: rtl/endp_inject_arbiter_rr.sv
// Parameterised N-way round-robin picker; the pointer moves to
// upd_idx+1 only when upd is asserted, so callers control fairness.
module inject_rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          upd,
    input  logic [IW-1:0] upd_idx,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW-1:0] ptr;
    int            idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (upd) begin
            ptr <= (upd_idx == IW'(N - 1)) ? '0 : upd_idx + IW'(1);
        end
    end

endmodule

// File: rtl/endp_inject_arbiter.sv
// Shares one NoC injection channel among NREQ requesters: per-packet
// round-robin, wormhole lock from header to tail, per-VC credit gating.
module endp_inject_arbiter
    import endp_inject_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    endp_req_if.slave       req,
    endp_flit_if.master     ch,
    output logic [V*Cw-1:0] credit_cnt,
    output logic [Nw-1:0]   owner,
    output logic            busy,
    output logic            err_proto,
    output logic            err_credit
);

    localparam logic [0:0] S_IDLE   = IDLE;
    localparam logic [0:0] S_LOCKED = LOCKED;

    logic [0:0]             state;
    logic [Vw-1:0]          locked_vc;
    logic [V-1:0][Cw-1:0]   cnt;
    logic [V-1:0]           has_cred;
    logic [V-1:0]           send;
    logic [V-1:0]           ovf;
    logic [Vw-1:0]          vc_a   [NREQ];
    logic [Fw-1:0]          flit_a [NREQ];
    logic [NREQ-1:0]        elig;
    logic [NREQ-1:0]        gnt;
    logic [Nw-1:0]          gnt_idx;
    logic [Nw-1:0]          sel;
    logic [Vw-1:0]          send_vc;
    logic                   gnt_any;
    logic                   idle;
    logic                   own_rdy;
    logic                   acc;
    logic                   upd;
    logic                   perr;
    ftype_t                 sel_type;

    assign idle = (state == S_IDLE);
    assign busy = ~idle;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign vc_a[i]   = req.vc[i*Vw +: Vw];
        assign flit_a[i] = req.flit[i*Fw +: Fw];
        assign elig[i]   = idle & req.valid[i] & req.hdr[i]
                         & has_cred[vc_a[i]];
    end

    inject_rr_arbiter #(.N(NREQ)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (elig),
        .upd     (upd),
        .upd_idx (sel),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Owner headers are refused while locked; body vc fields are ignored.
    assign own_rdy = ~idle & req.valid[owner] & ~req.hdr[owner]
                   & has_cred[locked_vc];

    assign acc      = idle ? gnt_any : own_rdy;
    assign sel      = idle ? gnt_idx : owner;
    assign send_vc  = idle ? vc_a[gnt_idx] : locked_vc;
    assign send     = acc ? (V'(1) << send_vc) : '0;
    assign sel_type = '{hdr: req.hdr[sel], tail: req.tail[sel]};
    assign upd      = acc & sel_type.tail;

    assign perr = idle ? |(req.valid & ~req.hdr)
                       : (req.valid[owner] & req.hdr[owner]);

    always_comb begin
        req.ready = '0;
        if (idle) req.ready = gnt;
        else      req.ready[owner] = own_rdy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            owner     <= '0;
            locked_vc <= '0;
            err_proto <= 1'b0;
        end else begin
            if (perr) err_proto <= 1'b1;
            unique case (state)
                S_IDLE: if (gnt_any) begin
                    owner <= gnt_idx;
                    if (!sel_type.tail) begin
                        state     <= S_LOCKED;
                        locked_vc <= vc_a[gnt_idx];
                    end
                end
                S_LOCKED: if (own_rdy && sel_type.tail) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch.wr   <= 1'b0;
            ch.flit <= '0;
            ch.hdr  <= 1'b0;
            ch.tail <= 1'b0;
            ch.vc   <= '0;
        end else begin
            ch.wr <= acc;
            if (acc) begin
                ch.flit <= flit_a[sel];
                ch.hdr  <= sel_type.hdr;
                ch.tail <= sel_type.tail;
                ch.vc   <= send;
            end
        end
    end

    // A send and a returned credit in the same cycle cancel out.
    for (genvar v = 0; v < V; v++) begin : g_cred
        assign has_cred[v] = (cnt[v] != '0);
        assign credit_cnt[v*Cw +: Cw] = cnt[v];
        assign ovf[v] = ~send[v] & ch.credit_in[v] & (cnt[v] == Cw'(B));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt[v] <= Cw'(B);
            end else if (send[v] && !ch.credit_in[v]) begin
                cnt[v] <= cnt[v] - Cw'(1);
            end else if (!send[v] && ch.credit_in[v] && !ovf[v]) begin
                cnt[v] <= cnt[v] + Cw'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    err_credit <= 1'b0;
        else if (|ovf) err_credit <= 1'b1;
    end

endmodule

// File: tb/tb_endp_inject_arbiter.sv
// Randomised and directed stimulus for endp_inject_arbiter with a
// packet-level reference model and a flit scoreboard.
module tb_endp_inject_arbiter;
    import endp_inject_arbiter_pkg::*;

    typedef struct packed {
        logic [Fw-1:0] d;
        logic          h;
        logic          t;
        logic [V-1:0]  vc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    endp_req_if  rq ();
    endp_flit_if ch ();

    logic [V*Cw-1:0] credit_cnt;
    logic [Nw-1:0]   owner;
    logic            busy;
    logic            err_proto;
    logic            err_credit;

    endp_inject_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req        (rq),
        .ch         (ch),
        .credit_cnt (credit_cnt),
        .owner      (owner),
        .busy       (busy),
        .err_proto  (err_proto),
        .err_credit (err_credit)
    );

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    // reference model state
    int m_cnt [V];
    int m_ptr, m_owner, m_lvc;
    bit m_locked, m_perr, m_cerr, m_wr;

    // requester packet generators
    int p_len [NREQ];
    int p_pos [NREQ];
    int p_vc  [NREQ];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_state();
        chk("flit_wr", 64'(ch.wr), 64'(m_wr));
        for (int v = 0; v < V; v++)
            chk("credit_cnt", 64'(credit_cnt[v*Cw +: Cw]), 64'(m_cnt[v]));
        chk("busy", 64'(busy), 64'(m_locked));
        chk("owner", 64'(owner), 64'(m_owner));
        chk("err_proto", 64'(err_proto), 64'(m_perr));
        chk("err_credit", 64'(err_credit), 64'(m_cerr));
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (ch.wr === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_flit: got flit %0h expected none",
                         ch.flit);
            end else begin
                e = sb.pop_front();
                chk("flit_out", 64'(ch.flit), 64'(e.d));
                chk("flit_hdr", 64'(ch.hdr), 64'(e.h));
                chk("flit_tail", 64'(ch.tail), 64'(e.t));
                chk("flit_vc", 64'(ch.vc), 64'(e.vc));
            end
        end
    end

    task automatic do_reset();
        logic [V*Cw-1:0] full;
        for (int v = 0; v < V; v++) full[v*Cw +: Cw] = Cw'(B);
        chk("sb_drained_at_reset", 64'(sb.size()), 64'd0);
        rq.valid = '0;
        ch.credit_in = '0;
        #1 reset = 1'b0;
        #1;
        chk("rst flit_wr", 64'(ch.wr), 64'd0);
        chk("rst flit_out", 64'(ch.flit), 64'd0);
        chk("rst flit_vc", 64'(ch.vc), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst owner", 64'(owner), 64'd0);
        chk("rst err_proto", 64'(err_proto), 64'd0);
        chk("rst err_credit", 64'(err_credit), 64'd0);
        chk("rst credit_cnt", 64'(credit_cnt), 64'(full));
        for (int v = 0; v < V; v++) m_cnt[v] = B;
        m_ptr = 0; m_owner = 0; m_lvc = 0;
        m_locked = 0; m_perr = 0; m_cerr = 0; m_wr = 0;
        sb.delete();
        for (int i = 0; i < NREQ; i++) begin
            p_len[i] = 0; p_pos[i] = 0; p_vc[i] = 0;
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock of stimulus; the model decides the expected grant.
    task automatic drive_cycle(input logic [NREQ-1:0] vm,
                               input logic [V-1:0] cr,
                               input logic [NREQ-1:0] kill);
        logic [NREQ-1:0]    h, t, exp_rdy;
        logic [NREQ*Vw-1:0] vcs;
        logic [NREQ*Fw-1:0] fl;
        int   vcv [NREQ];
        int   acc, svc, j;
        bit   s;
        exp_t e;
        @(negedge clk);
        check_state();
        for (int i = 0; i < NREQ; i++) begin
            if (p_pos[i] >= p_len[i]) begin
                p_len[i] = $urandom_range(4, 1);
                p_vc[i]  = $urandom_range(V - 1);
                p_pos[i] = 0;
            end
            h[i] = (p_pos[i] == 0) && !kill[i];
            t[i] = (p_pos[i] == p_len[i] - 1);
            vcv[i] = (p_pos[i] == 0) ? p_vc[i] : int'($urandom_range(V - 1));
            vcs[i*Vw +: Vw] = Vw'(vcv[i]);
            fl[i*Fw +: Fw] = Fw'($urandom);
        end
        rq.valid = vm; rq.hdr = h; rq.tail = t;
        rq.vc = vcs; rq.flit = fl;
        ch.credit_in = cr;
        #1;
        acc = -1;
        svc = 0;
        if (!m_locked) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (acc < 0 && vm[j] && h[j] && m_cnt[vcv[j]] > 0) acc = j;
            end
            for (int i = 0; i < NREQ; i++)
                if (vm[i] && !h[i]) m_perr = 1;
        end else if (vm[m_owner]) begin
            if (h[m_owner]) m_perr = 1;
            else if (m_cnt[m_lvc] > 0) acc = m_owner;
        end
        exp_rdy = '0;
        if (acc >= 0) exp_rdy[acc] = 1'b1;
        chk("req_ready", 64'(rq.ready), 64'(exp_rdy));
        if (acc >= 0) begin
            svc = m_locked ? m_lvc : vcv[acc];
            e.d = fl[acc*Fw +: Fw];
            e.h = h[acc];
            e.t = t[acc];
            e.vc = V'(1) << svc;
            sb.push_back(e);
            if (!m_locked) begin
                m_owner = acc;
                if (!t[acc]) begin
                    m_locked = 1;
                    m_lvc = svc;
                end
            end
            if (t[acc]) begin
                m_locked = 0;
                m_ptr = (acc + 1) % NREQ;
            end
            p_pos[acc]++;
        end
        for (int v = 0; v < V; v++) begin
            s = (acc >= 0) && (svc == v);
            if (s && !cr[v]) m_cnt[v]--;
            else if (cr[v] && !s) begin
                if (m_cnt[v] == B) m_cerr = 1;
                else m_cnt[v]++;
            end
        end
        m_wr = (acc >= 0);
        @(posedge clk);
        #1;
        rq.valid = '0;
        ch.credit_in = '0;
    endtask

    task automatic set_pkt(input int r, input int len, input int vc);
        p_len[r] = len; p_vc[r] = vc; p_pos[r] = 0;
    endtask

    initial begin
        logic [NREQ-1:0] vm;
        logic [V-1:0]    cr;
        rq.valid = '0; rq.hdr = '0; rq.tail = '0;
        rq.vc = '0; rq.flit = '0; ch.credit_in = '0;
        do_reset();

        // 3-flit packet from requester 2 on VC1
        set_pkt(2, 3, 1);
        repeat (3) drive_cycle(4'b0100, '0, '0);
        chk("A vc1 credits", 64'(credit_cnt[Cw +: Cw]), 64'd1);
        chk("A busy after tail", 64'(busy), 64'd0);

        // single-flit round robin from 0,1,3 with credits returned
        for (int n = 0; n < 6; n++) begin
            set_pkt(0, 1, 0); set_pkt(1, 1, 0); set_pkt(3, 1, 0);
            drive_cycle(4'b1011, (n < 3) ? 2'b11 : 2'b01, '0);
        end
        chk("B vc0 credits", 64'(credit_cnt[Cw-1:0]), 64'(B));

        // credit exhaustion on VC0 mid-packet
        set_pkt(1, 6, 0);
        repeat (5) drive_cycle(4'b0010, '0, '0);
        chk("C vc0 empty", 64'(credit_cnt[Cw-1:0]), 64'd0);
        chk("C still locked", 64'(busy), 64'd1);
        repeat (2) begin
            drive_cycle(4'b0010, 2'b01, '0);
            drive_cycle(4'b0010, '0, '0);
        end
        chk("C unlocked", 64'(busy), 64'd0);
        repeat (4) drive_cycle('0, 2'b01, '0);

        // simultaneous send and credit, then overflow
        repeat (2) begin
            set_pkt(0, 1, 0);
            drive_cycle(4'b0001, '0, '0);
        end
        set_pkt(0, 1, 0);
        drive_cycle(4'b0001, 2'b01, '0);
        chk("D cnt hold", 64'(credit_cnt[Cw-1:0]), 64'd2);
        repeat (3) drive_cycle('0, 2'b01, '0);
        chk("D saturate", 64'(credit_cnt[Cw-1:0]), 64'(B));
        chk("D err_credit", 64'(err_credit), 64'd1);

        // lock holds off another header; idle body flit is an error
        set_pkt(0, 3, 1);
        set_pkt(1, 1, 0);
        drive_cycle(4'b0001, '0, '0);
        repeat (2) drive_cycle(4'b0011, '0, '0);
        drive_cycle(4'b0010, '0, '0);
        chk("E owner", 64'(owner), 64'd1);
        set_pkt(2, 2, 0);
        drive_cycle(4'b0100, '0, 4'b0100);
        chk("E err_proto", 64'(err_proto), 64'd1);

        do_reset();
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++)
                vm[i] = ($urandom_range(99) < 65);
            for (int v = 0; v < V; v++)
                cr[v] = (m_cnt[v] < B) && ($urandom_range(99) < 40);
            drive_cycle(vm, cr, '0);
        end

        // asynchronous reset while locked on VC0
        do_reset();
        set_pkt(0, 5, 0);
        repeat (3) drive_cycle(4'b0001, '0, '0);
        chk("F busy", 64'(busy), 64'd1);
        chk("F vc0 cnt", 64'(credit_cnt[Cw-1:0]), 64'd1);
        do_reset();
        set_pkt(3, 1, 1);
        drive_cycle(4'b1000, '0, '0);
        repeat (2) drive_cycle('0, '0, '0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
